// File: rtl/servo_pkg.sv
// Shared constants and state encoding for the servo slew-rate limiter.
package servo_pkg;

    localparam logic [15:0] POS_CENTER = 16'd32768;

    // Evaluation happens this many counts before the frame counter wraps to zero.
    localparam int EVAL_OFS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

endpackage

// File: rtl/servo_ramp_step.sv
// One slew step: move position toward target by at most step; step of 0 jumps straight there.
module servo_ramp_step #(
    parameter int POS_W = 16
) (
    input  logic [POS_W-1:0] position_i,
    input  logic [POS_W-1:0] target_i,
    input  logic [POS_W-1:0] step_i,
    output logic [POS_W-1:0] next_position_o,
    output logic             arrived_o
);

    logic signed [POS_W:0] diff;
    logic        [POS_W:0] mag;

    // One extra bit so the full unsigned range differences never overflow.
    assign diff = $signed({1'b0, target_i}) - $signed({1'b0, position_i});
    assign mag  = diff[POS_W] ? $unsigned(-diff) : $unsigned(diff);

    assign arrived_o = (step_i == '0) || (mag <= {1'b0, step_i});

    always_comb begin
        next_position_o = target_i;
        if (!arrived_o) begin
            next_position_o = diff[POS_W] ? (position_i - step_i) : (position_i + step_i);
        end
    end

endmodule

// File: rtl/servo_ramp.sv
// Per-frame slew-rate limiter feeding the PWM stage; results land one cycle before the frame wrap.
module servo_ramp
    import servo_pkg::*;
#(
    parameter int CTR_LEN = 21,
    parameter int POS_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CTR_LEN-1:0] ctr,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [POS_W-1:0]   cmd_target,
    input  logic [POS_W-1:0]   cmd_step,
    output logic [POS_W-1:0]   position,
    output logic               update,
    output logic               busy,
    output logic               done
);

    localparam logic [POS_W-1:0]   CENTER   = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [CTR_LEN-1:0] EVAL_CTR = {CTR_LEN{1'b1}} - CTR_LEN'(EVAL_OFS - 1);

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] target_q, target_d;
    logic [POS_W-1:0] step_q, step_d;
    logic             busy_q, busy_d;
    logic             update_q, update_d;
    logic             done_q, done_d;

    logic             eval;
    logic             accept;
    logic [POS_W-1:0] next_pos;
    logic             arrived;

    assign cmd_ready = rst;
    assign eval      = (ctr == EVAL_CTR);
    assign accept    = cmd_valid && cmd_ready;

    servo_ramp_step #(
        .POS_W(POS_W)
    ) u_step (
        .position_i     (pos_q),
        .target_i       (target_q),
        .step_i         (step_q),
        .next_position_o(next_pos),
        .arrived_o      (arrived)
    );

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;
        step_d   = step_q;
        busy_d   = busy_q;
        update_d = 1'b0;
        done_d   = 1'b0;

        if (state_q == RAMP && eval) begin
            pos_d    = next_pos;
            update_d = 1'b1;
            if (arrived) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end

        // Evaluation above still used the old target/step; a fresh command wins the state.
        if (accept) begin
            target_d = cmd_target;
            step_d   = cmd_step;
            busy_d   = 1'b1;
            state_d  = RAMP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pos_q    <= CENTER;
            target_q <= CENTER;
            step_q   <= '0;
            busy_q   <= 1'b0;
            update_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            update_q <= update_d;
            done_q   <= done_d;
        end
    end

    assign position = pos_q;
    assign update   = update_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Scoreboard bench for servo_ramp with a compressed frame counter (low counts then a jump to the wrap region).
module tb_servo_ramp;
    import servo_pkg::*;

    localparam int CTR_LEN = 21;
    localparam int POS_W   = 16;
    localparam int MAXC    = (1 << CTR_LEN) - 1;
    localparam int EVAL    = (1 << CTR_LEN) - 3;
    localparam int FRAME   = 18;

    logic               clk;
    logic               rst;
    logic [CTR_LEN-1:0] ctr;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [POS_W-1:0]   cmd_target;
    logic [POS_W-1:0]   cmd_step;
    logic [POS_W-1:0]   position;
    logic               update;
    logic               busy;
    logic               done;

    servo_ramp #(.CTR_LEN(CTR_LEN), .POS_W(POS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctr       (ctr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .cmd_step  (cmd_step),
        .position  (position),
        .update    (update),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int pos;
        int done;
        int busy;
    } exp_t;

    exp_t q[$];
    int   seen[$];
    int   tests = 0;
    int   fails = 0;
    int   mpos, mtgt, mstep, mbusy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: once per frame, move toward target by at most step.
    initial begin
        exp_t e;
        int   d;
        int   mag;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mpos = 32768; mtgt = 32768; mstep = 0; mbusy = 0;
                q.delete();
            end else begin
                if (mbusy != 0 && int'(ctr) == EVAL) begin
                    d   = mtgt - mpos;
                    mag = (d < 0) ? -d : d;
                    e.done = 0;
                    if (mstep == 0 || mag <= mstep) begin
                        mpos   = mtgt;
                        mbusy  = 0;
                        e.done = 1;
                    end else begin
                        mpos = (d > 0) ? mpos + mstep : mpos - mstep;
                    end
                    e.pos = mpos;
                    if (cmd_valid) begin
                        mtgt = int'(cmd_target); mstep = int'(cmd_step); mbusy = 1;
                    end
                    e.busy = mbusy;
                    q.push_back(e);
                end else if (cmd_valid) begin
                    mtgt = int'(cmd_target); mstep = int'(cmd_step); mbusy = 1;
                end
            end
        end
    end

    // Monitor: pops one expectation per update strobe.
    initial begin
        exp_t e;
        int   c;
        forever begin
            @(posedge clk);
            c = int'(ctr);
            #1;
            if (rst) begin
                if (update) begin
                    seen.push_back(int'(position));
                    chk("upd_phase", int'(c == EVAL), 1);
                    if (q.size() == 0) begin
                        chk("unexpected_update", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("position", int'(position), e.pos);
                        chk("done", int'(done), e.done);
                        chk("busy", int'(busy), e.busy);
                    end
                end else if (done) begin
                    chk("done_without_update", 1, 0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        ctr = (ctr == CTR_LEN'(9)) ? CTR_LEN'(MAXC - 7) : ctr + CTR_LEN'(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int tgt, input int stp);
        cmd_valid  = 1'b1;
        cmd_target = POS_W'(tgt);
        cmd_step   = POS_W'(stp);
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_eval();
        int n = 0;
        while (int'(ctr) != EVAL && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("eval_timeout", int'(int'(ctr) == EVAL), 1);
    endtask

    task automatic wait_idle(input int frames);
        for (int i = 0; i < frames * FRAME && busy; i++) tick();
        chk("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        int tgt, stp;
        rst        = 1'b1;
        ctr        = '0;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_step   = '0;
        #2 rst = 1'b0;
        ticks(3);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_pos", int'(position), int'(POS_CENTER));
        chk("rst_busy", int'(busy), 0);
        chk("rst_update", int'(update), 0);
        rst = 1'b1;

        // Idle for three frames: no strobes
        ticks(3 * FRAME);
        chk("idle_strobes", seen.size(), 0);
        chk("idle_pos", int'(position), 32768);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(cmd_ready), 1);

        // Ramp up in three frames
        seen.delete();
        send(33000, 100);
        chk("ramp_busy", int'(busy), 1);
        wait_idle(6);
        chk("ramp_n", seen.size(), 3);
        chk("ramp_p0", seen[0], 32868);
        chk("ramp_p1", seen[1], 32968);
        chk("ramp_p2", seen[2], 33000);

        // Step 0 jumps in one frame
        seen.delete();
        send(1000, 0);
        wait_idle(3);
        ticks(2 * FRAME);
        chk("jump_n", seen.size(), 1);
        chk("jump_p0", seen[0], 1000);

        // Ramp down, retargeted on the first eval cycle
        send(33000, 0);
        wait_idle(3);
        seen.delete();
        send(32800, 64);
        wait_eval();
        send(40000, 5000);
        wait_idle(6);
        chk("retgt_n", seen.size(), 3);
        chk("retgt_p0", seen[0], 32936);
        chk("retgt_p1", seen[1], 37936);
        chk("retgt_p2", seen[2], 40000);

        // Target equals current position
        seen.delete();
        send(40000, 7);
        wait_idle(3);
        chk("same_n", seen.size(), 1);
        chk("same_p0", seen[0], 40000);

        // Async reset between evals
        seen.delete();
        send(20000, 10);
        for (int i = 0; i < 2 * FRAME && seen.size() == 0; i++) tick();
        ticks(3);
        rst = 1'b0;
        #1;
        chk("arst_pos", int'(position), 32768);
        chk("arst_busy", int'(busy), 0);
        chk("arst_update", int'(update), 0);
        chk("arst_done", int'(done), 0);
        ticks(2);
        rst = 1'b1;
        seen.delete();
        ticks(2 * FRAME);
        chk("arst_strobes", seen.size(), 0);
        chk("arst_hold", int'(position), 32768);

        // Randomized commands, some landing on the eval cycle
        for (int n = 0; n < 40; n++) begin
            ticks($urandom_range(0, 50));
            if ($urandom_range(0, 3) == 0) wait_eval();
            case ($urandom_range(0, 5))
                0:       tgt = mpos;
                1:       tgt = 0;
                2:       tgt = 65535;
                default: tgt = int'($urandom_range(0, 65535));
            endcase
            stp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(300, 9000));
            send(tgt, stp);
        end
        send(int'($urandom_range(0, 65535)), 0);
        wait_idle(3);
        ticks(FRAME);
        chk("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
